arm_regfile_2w: RTL and testbench

Parametrised successor to the 16x32 latch-based register file in the ARM datapath. Holds 2^ADDR_W edge-triggered registers, each DATA_W wide. Provides two combinational read ports, two write ports (ALU result and load write-back) and a dedicated program-counter register that auto-increments. Sits between decode (read addresses) and the execute/memory write-back stages.

---
 rtl/arm_regfile_2w_if.sv | 30 +++
 rtl/arm_regfile_2w.sv | 103 ++++++++++
 tb/tb_arm_regfile_2w.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_regfile_2w_if.sv
// Bus bundle for arm_regfile_2w: two write ports, two read ports, PC controls.
// The decode/write-back side uses the master modport, the register file the slave modport.
interface arm_regfile_2w_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              WE0;
  logic [ADDR_W-1:0] WA0;
  logic [DATA_W-1:0] WD0;
  logic              WE1;
  logic [ADDR_W-1:0] WA1;
  logic [DATA_W-1:0] WD1;
  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic [DATA_W-1:0] PA;
  logic [DATA_W-1:0] PB;
  logic              PC_EN;
  logic [DATA_W-1:0] PC_OUT;
  logic              WCOLL;

  modport master (
    output WE0, WA0, WD0, WE1, WA1, WD1, RA, RB, PC_EN,
    input  PA, PB, PC_OUT, WCOLL
  );

  modport slave (
    input  WE0, WA0, WD0, WE1, WA1, WD1, RA, RB, PC_EN,
    output PA, PB, PC_OUT, WCOLL
  );
endinterface

// File: rtl/arm_regfile_2w.sv
// Dual-write, dual-read register file with an auto-incrementing PC register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module arm_regfile_2w #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PC_IDX = 15,
  parameter int unsigned PC_INC = 4
) (
  input logic              CLK,
  input logic              RESET,
  arm_regfile_2w_if.slave  bus
);
  localparam int                NREGS   = 2 ** ADDR_W;
  localparam int                PC_I    = int'(PC_IDX);
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);
  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(PC_INC);

  if (PC_I >= NREGS) begin : g_bad_pc_idx
    $error("arm_regfile_2w: PC_IDX must be below 2**ADDR_W");
  end

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wcoll_q;
  logic              wcoll_d;
  logic              we1_eff_s;
  logic              pc_written_s;

`ifdef REGFILE_BYPASS_EN
  // Port 0 is checked first so a collision forwards the same data that gets stored.
  function automatic logic [DATA_W-1:0] fwd_read(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              we0,
    input logic [ADDR_W-1:0] wa0,
    input logic [DATA_W-1:0] wd0,
    input logic              we1,
    input logic [ADDR_W-1:0] wa1,
    input logic [DATA_W-1:0] wd1
  );
    logic [DATA_W-1:0] res;
    if (we0 && (wa0 == ra)) begin
      res = wd0;
    end else if (we1 && (wa1 == ra)) begin
      res = wd1;
    end else begin
      res = stored;
    end
    return res;
  endfunction
`endif

  // Next-state of every register: port 0, then unmasked port 1, then PC increment.
  always_comb begin
    wcoll_d      = bus.WE0 && bus.WE1 && (bus.WA0 == bus.WA1);
    we1_eff_s    = bus.WE1 && !wcoll_d;
    pc_written_s = (bus.WE0 && (bus.WA0 == PC_ADDR)) || (bus.WE1 && (bus.WA1 == PC_ADDR));
    for (int i = 0; i < NREGS; i++) begin
      if (bus.WE0 && (bus.WA0 == ADDR_W'(i))) begin
        regs_d[i] = bus.WD0;
      end else if (we1_eff_s && (bus.WA1 == ADDR_W'(i))) begin
        regs_d[i] = bus.WD1;
      end else if ((i == PC_I) && bus.PC_EN && !pc_written_s) begin
        regs_d[i] = regs_q[i] + PC_STEP;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // State registers with synchronous reset overriding writes and PC increment.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      wcoll_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      wcoll_q <= wcoll_d;
    end
  end

  // Read ports; reset forces zero even before the first clearing edge.
  always_comb begin
    if (RESET) begin
      bus.PA = '0;
      bus.PB = '0;
    end else begin
`ifdef REGFILE_BYPASS_EN
      bus.PA = fwd_read(bus.RA, regs_q[bus.RA], bus.WE0, bus.WA0, bus.WD0,
                        bus.WE1, bus.WA1, bus.WD1);
      bus.PB = fwd_read(bus.RB, regs_q[bus.RB], bus.WE0, bus.WA0, bus.WD0,
                        bus.WE1, bus.WA1, bus.WD1);
`else
      bus.PA = regs_q[bus.RA];
      bus.PB = regs_q[bus.RB];
`endif
    end
    bus.PC_OUT = regs_q[PC_I];
    bus.WCOLL  = wcoll_q;
  end
endmodule

// File: tb/tb_arm_regfile_2w.sv
// Bench for arm_regfile_2w: default 32-bit instance plus a 16-bit/8-register instance,
// directed vector table, 16-bit PC wrap sequence and randomized model comparison.
module tb_arm_regfile_2w;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        we0;
    logic [3:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        pcen;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        chk;
    logic [31:0] pa;
    logic [31:0] pb;
    logic [31:0] pc;
    logic        wc;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  arm_regfile_2w_if #(.DATA_W(32), .ADDR_W(4)) b0 ();
  arm_regfile_2w_if #(.DATA_W(16), .ADDR_W(3)) b1 ();

  arm_regfile_2w #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15), .PC_INC(4)) dut0 (
    .CLK(CLK), .RESET(RESET), .bus(b0.slave));
  arm_regfile_2w #(.DATA_W(16), .ADDR_W(3), .PC_IDX(7), .PC_INC(2)) dut1 (
    .CLK(CLK), .RESET(RESET), .bus(b1.slave));

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mdl [2][16];
  logic        mcoll [2];
  bit          mvalid = 1'b0;
  int          nregs [2] = '{16, 8};
  int          pcidx [2] = '{15, 7};
  logic [31:0] pcinc [2] = '{32'd4, 32'd2};
  logic [31:0] dmask [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
  vec_t        tbl [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic stim_t st(input logic rst, input logic we0, input logic [3:0] wa0,
                               input logic [31:0] wd0, input logic we1, input logic [3:0] wa1,
                               input logic [31:0] wd1, input logic [3:0] ra, input logic [3:0] rb,
                               input logic pcen);
    stim_t s;
    s.rst = rst; s.we0 = we0; s.wa0 = wa0; s.wd0 = wd0; s.we1 = we1;
    s.wa1 = wa1; s.wd1 = wd1; s.ra = ra; s.rb = rb; s.pcen = pcen;
    return s;
  endfunction

  // Expected read value from the reference model (state before the coming edge).
  function automatic logic [31:0] exp_read(input int k, input stim_t s, input logic [3:0] raw);
    int a;
    int w0;
    int w1;
    a  = int'(raw) % nregs[k];
    w0 = int'(s.wa0) % nregs[k];
    w1 = int'(s.wa1) % nregs[k];
    if (s.rst) return 32'h0;
    if (BYP && s.we0 && (w0 == a)) return s.wd0 & dmask[k];
    if (BYP && s.we1 && (w1 == a)) return s.wd1 & dmask[k];
    return mdl[k][a];
  endfunction

  // Reference model edge: port 1 stored first so port 0 naturally overwrites it.
  task automatic model_edge(input int k, input stim_t s);
    int          w0;
    int          w1;
    int          pc;
    logic [31:0] old;
    bit          pcw;
    w0 = int'(s.wa0) % nregs[k];
    w1 = int'(s.wa1) % nregs[k];
    pc = pcidx[k];
    if (s.rst) begin
      for (int i = 0; i < 16; i++) mdl[k][i] = 32'h0;
      mcoll[k] = 1'b0;
    end else begin
      old = mdl[k][pc];
      pcw = (s.we0 && (w0 == pc)) || (s.we1 && (w1 == pc));
      mcoll[k] = s.we0 && s.we1 && (w0 == w1);
      if (s.we1) mdl[k][w1] = s.wd1 & dmask[k];
      if (s.we0) mdl[k][w0] = s.wd0 & dmask[k];
      if (!pcw && s.pcen) mdl[k][pc] = (old + pcinc[k]) & dmask[k];
    end
  endtask

  task automatic drive(input stim_t s);
    RESET    = s.rst;
    b0.WE0   = s.we0;   b0.WA0 = s.wa0;      b0.WD0 = s.wd0;
    b0.WE1   = s.we1;   b0.WA1 = s.wa1;      b0.WD1 = s.wd1;
    b0.RA    = s.ra;    b0.RB  = s.rb;       b0.PC_EN = s.pcen;
    b1.WE0   = s.we0;   b1.WA0 = s.wa0[2:0]; b1.WD0 = s.wd0[15:0];
    b1.WE1   = s.we1;   b1.WA1 = s.wa1[2:0]; b1.WD1 = s.wd1[15:0];
    b1.RA    = s.ra[2:0]; b1.RB = s.rb[2:0]; b1.PC_EN = s.pcen;
  endtask

  // Drive at the falling edge and compare both instances against the model.
  task automatic pre(input stim_t s);
    @(negedge CLK);
    drive(s);
    #1;
    chk("pa32", b0.PA, exp_read(0, s, s.ra));
    chk("pb32", b0.PB, exp_read(0, s, s.rb));
    chk("pa16", {16'h0, b1.PA}, exp_read(1, s, s.ra));
    chk("pb16", {16'h0, b1.PB}, exp_read(1, s, s.rb));
    if (mvalid) begin
      chk("pc32", b0.PC_OUT, mdl[0][15]);
      chk("pc16", {16'h0, b1.PC_OUT}, mdl[1][7]);
      chk("wcoll32", {31'h0, b0.WCOLL}, {31'h0, mcoll[0]});
      chk("wcoll16", {31'h0, b1.WCOLL}, {31'h0, mcoll[1]});
    end
  endtask

  task automatic post(input stim_t s);
    @(posedge CLK);
    model_edge(0, s);
    model_edge(1, s);
    if (s.rst) mvalid = 1'b1;
  endtask

  task automatic cycle(input stim_t s);
    pre(s);
    post(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    logic [31:0] exp_pc16 [3];
    logic [31:0] exp_pc32 [3];
    exp_pc16 = '{32'hFFFE, 32'h0000, 32'h0002};
    exp_pc32 = '{32'h4, 32'h8, 32'hC};

    //            rst   we0  wa0    wd0            we1  wa1    wd1         ra     rb     pcen
    tbl[0].s  = st(1'b1, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd3,  4'd3,  1'b0);
    tbl[1].s  = st(1'b0, 1'b1, 4'd3,  32'hDEADBEEF,  1'b0, 4'd0,  32'h0,     4'd3,  4'd15, 1'b0);
    tbl[2].s  = st(1'b1, 1'b1, 4'd3,  32'h5,         1'b0, 4'd0,  32'h0,     4'd3,  4'd3,  1'b1);
    tbl[3].s  = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd3,  4'd15, 1'b0);
    tbl[4].s  = st(1'b0, 1'b1, 4'd2,  32'h11,        1'b1, 4'd7,  32'h22,    4'd1,  4'd1,  1'b0);
    tbl[5].s  = st(1'b0, 1'b1, 4'd4,  32'hAAAA,      1'b1, 4'd4,  32'hBBBB,  4'd2,  4'd7,  1'b0);
    tbl[6].s  = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd4,  4'd4,  1'b0);
    tbl[7].s  = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd4,  4'd2,  1'b0);
    tbl[8].s  = st(1'b0, 1'b1, 4'd15, 32'hFFFFFFF8,  1'b0, 4'd0,  32'h0,     4'd0,  4'd0,  1'b1);
    tbl[9].s  = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd15, 4'd0,  1'b1);
    tbl[10].s = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd15, 4'd0,  1'b1);
    tbl[11].s = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd15, 4'd0,  1'b1);
    tbl[12].s = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd15, 4'd0,  1'b0);
    tbl[13].s = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b1, 4'd15, 32'h100,   4'd0,  4'd0,  1'b1);
    tbl[14].s = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd15, 4'd0,  1'b0);
    tbl[15].s = st(1'b0, 1'b1, 4'd9,  32'h1234,      1'b0, 4'd0,  32'h0,     4'd9,  4'd9,  1'b0);
    tbl[16].s = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd9,  4'd5,  1'b0);
    tbl[17].s = st(1'b0, 1'b1, 4'd6,  32'hA,         1'b1, 4'd6,  32'hB,     4'd6,  4'd6,  1'b0);
    tbl[18].s = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd6,  4'd0,  1'b0);
    tbl[19].s = st(1'b1, 1'b1, 4'd6,  32'h77,        1'b0, 4'd0,  32'h0,     4'd6,  4'd6,  1'b1);
    tbl[20].s = st(1'b0, 1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,     4'd6,  4'd15, 1'b0);

    // Hand-derived expectations for the 32-bit instance: {chk, pa, pb, pc, wcoll}.
    tbl[0].chk  = 1'b0; tbl[0].pa  = 32'h0; tbl[0].pb  = 32'h0; tbl[0].pc  = 32'h0; tbl[0].wc  = 1'b0;
    tbl[1].chk  = 1'b1; tbl[1].pa  = BYP ? 32'hDEADBEEF : 32'h0; tbl[1].pb = 32'h0; tbl[1].pc = 32'h0; tbl[1].wc = 1'b0;
    tbl[2].chk  = 1'b1; tbl[2].pa  = 32'h0; tbl[2].pb  = 32'h0; tbl[2].pc  = 32'h0; tbl[2].wc  = 1'b0;
    tbl[3].chk  = 1'b1; tbl[3].pa  = 32'h0; tbl[3].pb  = 32'h0; tbl[3].pc  = 32'h0; tbl[3].wc  = 1'b0;
    tbl[4].chk  = 1'b1; tbl[4].pa  = 32'h0; tbl[4].pb  = 32'h0; tbl[4].pc  = 32'h0; tbl[4].wc  = 1'b0;
    tbl[5].chk  = 1'b1; tbl[5].pa  = 32'h11; tbl[5].pb = 32'h22; tbl[5].pc = 32'h0; tbl[5].wc  = 1'b0;
    tbl[6].chk  = 1'b1; tbl[6].pa  = 32'hAAAA; tbl[6].pb = 32'hAAAA; tbl[6].pc = 32'h0; tbl[6].wc = 1'b1;
    tbl[7].chk  = 1'b1; tbl[7].pa  = 32'hAAAA; tbl[7].pb = 32'h11; tbl[7].pc = 32'h0; tbl[7].wc = 1'b0;
    tbl[8].chk  = 1'b1; tbl[8].pa  = 32'h0; tbl[8].pb  = 32'h0; tbl[8].pc  = 32'h0; tbl[8].wc  = 1'b0;
    tbl[9].chk  = 1'b1; tbl[9].pa  = 32'hFFFFFFF8; tbl[9].pb = 32'h0; tbl[9].pc = 32'hFFFFFFF8; tbl[9].wc = 1'b0;
    tbl[10].chk = 1'b1; tbl[10].pa = 32'hFFFFFFFC; tbl[10].pb = 32'h0; tbl[10].pc = 32'hFFFFFFFC; tbl[10].wc = 1'b0;
    tbl[11].chk = 1'b1; tbl[11].pa = 32'h0; tbl[11].pb = 32'h0; tbl[11].pc = 32'h0; tbl[11].wc = 1'b0;
    tbl[12].chk = 1'b1; tbl[12].pa = 32'h4; tbl[12].pb = 32'h0; tbl[12].pc = 32'h4; tbl[12].wc = 1'b0;
    tbl[13].chk = 1'b1; tbl[13].pa = 32'h0; tbl[13].pb = 32'h0; tbl[13].pc = 32'h4; tbl[13].wc = 1'b0;
    tbl[14].chk = 1'b1; tbl[14].pa = 32'h100; tbl[14].pb = 32'h0; tbl[14].pc = 32'h100; tbl[14].wc = 1'b0;
    tbl[15].chk = 1'b1; tbl[15].pa = BYP ? 32'h1234 : 32'h0; tbl[15].pb = BYP ? 32'h1234 : 32'h0; tbl[15].pc = 32'h100; tbl[15].wc = 1'b0;
    tbl[16].chk = 1'b1; tbl[16].pa = 32'h1234; tbl[16].pb = 32'h0; tbl[16].pc = 32'h100; tbl[16].wc = 1'b0;
    tbl[17].chk = 1'b1; tbl[17].pa = BYP ? 32'hA : 32'h0; tbl[17].pb = BYP ? 32'hA : 32'h0; tbl[17].pc = 32'h100; tbl[17].wc = 1'b0;
    tbl[18].chk = 1'b1; tbl[18].pa = 32'hA; tbl[18].pb = 32'h0; tbl[18].pc = 32'h100; tbl[18].wc = 1'b1;
    tbl[19].chk = 1'b1; tbl[19].pa = 32'h0; tbl[19].pb = 32'h0; tbl[19].pc = 32'h100; tbl[19].wc = 1'b0;
    tbl[20].chk = 1'b1; tbl[20].pa = 32'h0; tbl[20].pb = 32'h0; tbl[20].pc = 32'h0; tbl[20].wc = 1'b0;

    for (int i = 0; i < 21; i++) begin
      pre(tbl[i].s);
      chk($sformatf("vec%0d_pa", i), b0.PA, tbl[i].pa);
      chk($sformatf("vec%0d_pb", i), b0.PB, tbl[i].pb);
      if (tbl[i].chk) begin
        chk($sformatf("vec%0d_pc", i), b0.PC_OUT, tbl[i].pc);
        chk($sformatf("vec%0d_wcoll", i), {31'h0, b0.WCOLL}, {31'h0, tbl[i].wc});
      end
      post(tbl[i].s);
    end

    // 16-bit PC wrap: load 0xFFFC into r7 of the small instance, then step three times.
    cycle(st(1'b0, 1'b1, 4'd7, 32'hFFFC, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      cycle(st(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd7, 4'd15, 1'b1));
      #1;
      chk($sformatf("wrap16_%0d", i), {16'h0, b1.PC_OUT}, exp_pc16[i]);
      chk($sformatf("inc32_%0d", i), b0.PC_OUT, exp_pc32[i]);
    end

    for (int n = 0; n < 600; n++) begin
      s.rst  = ($urandom_range(0, 39) == 0);
      s.we0  = $urandom_range(0, 1) == 1;
      s.we1  = $urandom_range(0, 1) == 1;
      s.wa0  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      s.wa1  = ($urandom_range(0, 2) == 0) ? s.wa0 : 4'($urandom_range(0, 15));
      s.wd0  = $urandom;
      s.wd1  = $urandom;
      s.ra   = ($urandom_range(0, 2) == 0) ? s.wa0 : 4'($urandom_range(0, 15));
      s.rb   = ($urandom_range(0, 2) == 0) ? s.wa1 : 4'($urandom_range(0, 15));
      s.pcen = $urandom_range(0, 1) == 1;
      cycle(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
